uart_tx_arbiter: RTL and testbench

- Round-robin arbiter sharing the single UART transmitter of uart_system between NUM_REQ packet sources.
- Grants one requester at a time and holds the grant until that requester's last byte has left the transmitter, so packets never interleave.
- Drives txByteStart/byteForTx and paces itself on tx_ready.
- Flags a transmitter that fails to respond to a start request.

---
 rtl/uart_tx_arbiter.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ packet sources onto one UART transmitter; grant is held per packet.
// Latency: grant one cycle after req_valid; tx_start one cycle after a byte is accepted.
// Backpressure: req_ready only for the owner, only in SEND with tx_ready high; one byte per transmitter busy/idle cycle.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          tx_ready,
  output logic                          tx_start,
  output logic [DATA_WIDTH-1:0]         tx_byte,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          err_timeout
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t                  state, state_d;
  logic [GW-1:0]           rr_ptr, rr_ptr_d;
  logic [GW-1:0]           grant_d;
  logic                    busy_d;
  logic                    tx_start_d;
  logic [DATA_WIDTH-1:0]   tx_byte_d;
  logic                    last_q, last_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic                    err_d;

  logic                    found;
  logic [GW-1:0]           pick;
  logic [GW-1:0]           cand;
  logic                    accept;
  logic                    byte_done;
  logic [DATA_WIDTH-1:0]   slice [NUM_REQ];

  // Unpack the flat data bus into one byte per requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign slice[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Round-robin search: first valid requester after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = GW'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Only the current owner can be accepted, and only while the transmitter is idle in SEND.
  always_comb begin
    req_ready = '0;
    if (state == SEND) begin
      req_ready[grant_id] = req_valid[grant_id] & tx_ready;
    end
  end

  assign accept = (state == SEND) && req_valid[grant_id] && tx_ready;

  // Next-state and next-output logic; a timed-out start is handled like a completed byte.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    grant_d    = grant_id;
    busy_d     = busy;
    tx_start_d = 1'b0;
    tx_byte_d  = tx_byte;
    last_d     = last_q;
    cnt_d      = cnt;
    err_d      = err_timeout;
    byte_done  = 1'b0;

    case (state)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          busy_d  = 1'b1;
          state_d = SEND;
        end
      end

      SEND: begin
        // A stalled owner keeps the grant indefinitely; no timeout applies here.
        if (accept) begin
          tx_byte_d  = slice[grant_id];
          last_d     = req_last[grant_id];
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = WAIT_LOW;
        end
      end

      WAIT_LOW: begin
        cnt_d = cnt + 1'b1;
        if (!tx_ready) begin
          state_d = WAIT_HIGH;
        end else if (cnt_d == CW'(ACK_TIMEOUT)) begin
          err_d     = 1'b1;
          byte_done = 1'b1;
        end
      end

      WAIT_HIGH: begin
        if (tx_ready) begin
          byte_done = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // End of a byte: release after the last one, otherwise fetch the next byte.
    if (byte_done) begin
      if (last_q) begin
        rr_ptr_d = grant_id;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end else begin
        state_d  = SEND;
      end
    end
  end

  // State and output registers with synchronous reset; reset aborts any packet in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= GW'(NUM_REQ - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      tx_start    <= 1'b0;
      tx_byte     <= '0;
      last_q      <= 1'b0;
      cnt         <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      grant_id    <= grant_d;
      busy        <= busy_d;
      tx_start    <= tx_start_d;
      tx_byte     <= tx_byte_d;
      last_q      <= last_d;
      cnt         <= cnt_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter and per-requester byte queues.
// Transmitter: tx_ready falls one cycle after tx_start and rises ten cycles later (or never, when dead).
// Every comparison goes through chk; expected bytes and owners are written out by hand per test.
module tb_uart_tx_arbiter;

  localparam int NR  = 4;
  localparam int DW  = 8;
  localparam int TMO = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]  req_last = '0;
  logic [NR-1:0]  req_ready;
  logic           tx_ready = 1'b1;
  logic           tx_start;
  logic [DW-1:0]  tx_byte;
  logic           busy;
  logic [1:0]     grant_id;
  logic           err_timeout;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .tx_ready(tx_ready), .tx_start(tx_start), .tx_byte(tx_byte),
    .busy(busy), .grant_id(grant_id), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Requester queues (main writes plen/hold, driver advances pidx).
  logic [7:0] pdat  [NR][16];
  logic       plast [NR][16];
  int         plen  [NR];
  int         pidx  [NR];
  logic       hold  [NR];
  logic       dead = 1'b0;

  // Driver/monitor state.
  logic [NR-1:0] acc = '0;
  int         rdy_cnt [NR];
  logic [7:0] log_byte [128];
  int         log_gid  [128];
  int         log_n = 0;
  int         cyc = 0, start_cyc = 0, rise_cyc = 0, fall_cyc = 0, err_cyc = 0;
  int         tx_low = 0, ovl = 0;
  logic       tx_pend = 1'b0, busy_prev = 1'b0, err_prev = 1'b0;

  // Expected log for the current test.
  logic [7:0] eb [8];
  int         eg [8];
  int         lb, ovl0, rdy0;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Transmitter model, requester drivers and monitors, all on the falling edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < NR; i++) begin
      if (acc[i]) begin
        pidx[i]++;
        rdy_cnt[i]++;
      end
    end
    if (tx_start) begin
      if (!tx_ready) ovl++;
      if (log_n < 128) begin
        log_byte[log_n] = tx_byte;
        log_gid[log_n]  = int'(grant_id);
      end
      log_n++;
      start_cyc = cyc;
    end
    if (busy_prev && !busy) fall_cyc = cyc;
    if (err_timeout && !err_prev) err_cyc = cyc;
    busy_prev = busy;
    err_prev  = err_timeout;

    if (rst) begin
      tx_ready = 1'b1;
      tx_pend  = 1'b0;
    end else if (tx_pend) begin
      tx_ready = 1'b0;
      tx_low   = 10;
      tx_pend  = 1'b0;
    end else if (!tx_ready) begin
      tx_low--;
      if (tx_low == 0) begin
        tx_ready = 1'b1;
        rise_cyc = cyc;
      end
    end
    if (!rst && tx_start && !dead) tx_pend = 1'b1;

    for (int i = 0; i < NR; i++) begin
      if (pidx[i] < plen[i] && !hold[i]) begin
        req_valid[i]          = 1'b1;
        req_data[i*DW +: DW]  = pdat[i][pidx[i]];
        req_last[i]           = plast[i][pidx[i]];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i]  = 1'b0;
      end
    end
    #1;
    acc = req_ready;
    if ((req_ready & ~{NR{tx_ready}}) != '0) ovl++;
  end

  task automatic push(input int r, input logic [7:0] d, input logic l);
    pdat[r][plen[r]]  = d;
    plast[r][plen[r]] = l;
    plen[r]           = plen[r] + 1;
  endtask

  task automatic mark();
    lb   = log_n;
    ovl0 = ovl;
    rdy0 = rdy_cnt[0];
  endtask

  function automatic bit drained();
    bit d = 1'b1;
    for (int i = 0; i < NR; i++) if (pidx[i] != plen[i]) d = 1'b0;
    return d;
  endfunction

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    bit done = 1'b0;
    while (!done && n < budget) begin
      @(negedge clk); #2;
      n++;
      done = !busy && drained();
    end
    if (!done) chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_log(input string tag, input int n, input int budget);
    int k = 0;
    while ((log_n - lb) < n && k < budget) begin
      @(negedge clk); #2;
      k++;
    end
    if ((log_n - lb) < n) chk({tag, "_start_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_log(input string tag, input int n);
    chk({tag, "_nstart"}, log_n - lb, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), log_byte[lb+i], eb[i]);
      chk($sformatf("%s_gid%0d", tag, i), log_gid[lb+i], eg[i]);
    end
  endtask

  // One reset cycle; queues abort, outputs must all be zero right after it.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      plen[i] = pidx[i];
      hold[i] = 1'b0;
    end
    @(negedge clk); #2;
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_grant_id"}, grant_id, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NR; i++) begin
      plen[i] = 0; pidx[i] = 0; hold[i] = 1'b0; rdy_cnt[i] = 0;
    end
    repeat (2) @(negedge clk);
    #2;
    do_reset("rst0");

    // Test 1: 3-byte packet from requester 0.
    mark();
    push(0, 8'hA1, 1'b0); push(0, 8'hA2, 1'b0); push(0, 8'hA3, 1'b1);
    @(negedge clk); #2;
    chk("t1_busy_before_grant", busy, 0);
    @(negedge clk); #2;
    chk("t1_busy_at_grant", busy, 1);
    chk("t1_grant_id", grant_id, 0);
    wait_idle("t1", 300);
    eb = '{8'hA1, 8'hA2, 8'hA3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    eg = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_log("t1", 3);
    chk("t1_req_ready0_pulses", rdy_cnt[0] - rdy0, 3);
    chk("t1_busy_fall_after_rise", fall_cyc - rise_cyc, 1);
    chk("t1_overlap", ovl - ovl0, 0);

    // Test 2: all four requesting single-byte packets; requester 0 has a second one.
    do_reset("rst2");
    mark();
    push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
    push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
    wait_idle("t2", 500);
    eb = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h00, 8'h00, 8'h00};
    eg = '{0, 1, 2, 3, 0, 0, 0, 0};
    check_log("t2", 5);
    chk("t2_overlap", ovl - ovl0, 0);

    // Test 3: requester 1 arrives mid-packet of requester 2 and must wait.
    mark();
    push(2, 8'h20, 1'b0); push(2, 8'h21, 1'b0); push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    wait_log("t3", 1, 100);
    push(1, 8'h30, 1'b0); push(1, 8'h31, 1'b1);
    wait_idle("t3", 500);
    eb = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h00, 8'h00};
    eg = '{2, 2, 2, 2, 1, 1, 0, 0};
    check_log("t3", 6);

    // Test 4: dead transmitter, start never acknowledged.
    mark();
    dead = 1'b1;
    push(3, 8'h44, 1'b1);
    wait_idle("t4", 300);
    eb = '{8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    eg = '{3, 0, 0, 0, 0, 0, 0, 0};
    check_log("t4", 1);
    chk("t4_err_delay", err_cyc - start_cyc, TMO);
    chk("t4_err_set", err_timeout, 1);
    chk("t4_grant_held", grant_id, 3);
    dead = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    chk("t4_err_sticky", err_timeout, 1);

    // Test 5: owner stalls after byte 1 while requester 1 waits.
    mark();
    push(0, 8'h50, 1'b0); push(0, 8'h51, 1'b0); push(0, 8'h52, 1'b1);
    wait_log("t5", 1, 100);
    hold[0] = 1'b1;
    push(1, 8'h61, 1'b1);
    repeat (50) @(negedge clk);
    #2;
    chk("t5_no_start_while_stalled", log_n - lb, 1);
    chk("t5_busy_while_stalled", busy, 1);
    chk("t5_grant_while_stalled", grant_id, 0);
    hold[0] = 1'b0;
    wait_idle("t5", 500);
    eb = '{8'h50, 8'h51, 8'h52, 8'h61, 8'h00, 8'h00, 8'h00, 8'h00};
    eg = '{0, 0, 0, 1, 0, 0, 0, 0};
    check_log("t5", 4);
    chk("t5_err_still_set", err_timeout, 1);

    // Test 6: reset during WAIT_HIGH mid-packet, then requester 0 wins first.
    mark();
    push(2, 8'h70, 1'b0); push(2, 8'h71, 1'b0); push(2, 8'h72, 1'b1);
    wait_log("t6", 1, 100);
    repeat (3) @(negedge clk);
    #2;
    chk("t6_busy_before_rst", busy, 1);
    do_reset("rst6");
    mark();
    push(2, 8'h82, 1'b1); push(0, 8'h80, 1'b1);
    wait_idle("t6", 300);
    eb = '{8'h80, 8'h82, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    eg = '{0, 2, 0, 0, 0, 0, 0, 0};
    check_log("t6", 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
